// File: rtl/nibble_serial_comparator.sv
// nibble_serial_comparator
//
// Compares two WIDTH-bit unsigned operands by stepping one 4-bit magnitude
// comparator slice across the operand nibbles, MSB nibble first. The walk
// stops at the first unequal nibble. Operands are captured when a start is
// accepted. The result is reported as a one-cycle done pulse plus e/g/l
// flags that hold until the next accepted start.
//
// WIDTH must be a multiple of 4 and at least 4.

// ---------------------------------------------------------------------------
// 4-bit magnitude comparator cell (the existing slice this controller reuses)
// ---------------------------------------------------------------------------
module nibble_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       e,
    output logic       g,
    output logic       l
);

    // Pure combinational unsigned compare of one nibble pair.
    always_comb begin
        e = (a == b);
        g = (a > b);
        l = (a < b);
    end

endmodule : nibble_cmp4

// ---------------------------------------------------------------------------
// Serial comparator controller
// ---------------------------------------------------------------------------
module nibble_serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             e,
    output logic             g,
    output logic             l
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Index of the most significant nibble; the walk starts here.
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Registered state
    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [IW-1:0]    idx;

    // Next-state values
    state_t           state_nx;
    logic [WIDTH-1:0] ra_nx;
    logic [WIDTH-1:0] rb_nx;
    logic [IW-1:0]    idx_nx;
    logic             done_nx;
    logic             e_nx;
    logic             g_nx;
    logic             l_nx;

    // Nibble currently presented to the slice, and the slice verdict
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_e;
    logic             slice_g;
    logic             slice_l;

    // Select nibble idx of the captured operands as a plain mux. This stays
    // clean for any N, including N that is not a power of two.
    // NOTE: every signal written in an always_comb gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                slice_a = ra[4*i +: 4];
                slice_b = rb[4*i +: 4];
            end
        end
    end

    // One shared slice; its outputs feed only the next-state logic.
    nibble_cmp4 u_slice (
        .a (slice_a),
        .b (slice_b),
        .e (slice_e),
        .g (slice_g),
        .l (slice_l)
    );

    // Next-state and result logic. Everything holds by default, and done
    // defaults low so that it can only ever be a single-cycle pulse.
    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // defaults; the clocked block below uses non-blocking '<=' only.
    always_comb begin
        state_nx = state;
        ra_nx    = ra;
        rb_nx    = rb;
        idx_nx   = idx;
        done_nx  = 1'b0;
        e_nx     = e;
        g_nx     = g;
        l_nx     = l;

        unique case (state)
            IDLE: begin
                if (start) begin
                    ra_nx    = a;
                    rb_nx    = b;
                    idx_nx   = IDX_TOP;
                    e_nx     = 1'b0;
                    g_nx     = 1'b0;
                    l_nx     = 1'b0;
                    state_nx = CMP;
                end
            end

            CMP: begin
                if (slice_g) begin
                    g_nx     = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (slice_l) begin
                    l_nx     = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (idx == '0) begin
                    // Every nibble matched, down to nibble 0.
                    e_nx     = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx - IW'(1);
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, operand and result registers. Reset discards any compare that
    // is in flight.
    // NOTE: the operand copies are reset along with the control state, so
    // ra/rb never hold stale data from before a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= '0;
            done  <= 1'b0;
            e     <= 1'b0;
            g     <= 1'b0;
            l     <= 1'b0;
        end else begin
            state <= state_nx;
            ra    <= ra_nx;
            rb    <= rb_nx;
            idx   <= idx_nx;
            done  <= done_nx;
            e     <= e_nx;
            g     <= g_nx;
            l     <= l_nx;
        end
    end

    // busy is decoded from the state register only, never from inputs.
    always_comb begin
        busy = (state == CMP);
    end

endmodule : nibble_serial_comparator

// File: tb/tb_nibble_serial_comparator.sv
// Testbench for nibble_serial_comparator. It drives three instances, with
// WIDTH = 16, 8 and 4, from one directed sequence. The bench computes each
// expected result and latency itself, pushes it to a scoreboard queue when
// the start is driven, and pops it when done appears.
module tb_nibble_serial_comparator;

    typedef struct packed {
        logic e;
        logic g;
        logic l;
        int   p;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        e_v     [3];
    logic        g_v     [3];
    logic        l_v     [3];

    int   checks;
    int   errors;
    exp_t sb [$];

    nibble_serial_comparator #(.WIDTH(16)) u_w16 (
        .clk (clk), .rst (rst), .start (start_v[0]),
        .a (a_v[0]), .b (b_v[0]),
        .busy (busy_v[0]), .done (done_v[0]),
        .e (e_v[0]), .g (g_v[0]), .l (l_v[0])
    );

    nibble_serial_comparator #(.WIDTH(8)) u_w8 (
        .clk (clk), .rst (rst), .start (start_v[1]),
        .a (a_v[1][7:0]), .b (b_v[1][7:0]),
        .busy (busy_v[1]), .done (done_v[1]),
        .e (e_v[1]), .g (g_v[1]), .l (l_v[1])
    );

    nibble_serial_comparator #(.WIDTH(4)) u_w4 (
        .clk (clk), .rst (rst), .start (start_v[2]),
        .a (a_v[2][3:0]), .b (b_v[2][3:0]),
        .busy (busy_v[2]), .done (done_v[2]),
        .e (e_v[2]), .g (g_v[2]), .l (l_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence itself gets stuck.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed no end, required end of sequence");
        $fatal(1);
    end

    function automatic int unit_width(input int u);
        return (u == 0) ? 16 : (u == 1) ? 8 : 4;
    endfunction

    function automatic logic [15:0] unit_mask(input int u);
        logic [16:0] one;
        one = 17'h1;
        return 16'((one << unit_width(u)) - 17'h1);
    endfunction

    // Position of the first unequal nibble from the MSB (1..n), or n if equal.
    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y,
                                      input int w);
        int n;
        n = w / 4;
        for (int i = n - 1; i >= 0; i--) begin
            if (x[4*i +: 4] != y[4*i +: 4]) return n - i;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] egl(input int u);
        return {29'd0, e_v[u], g_v[u], l_v[u]};
    endfunction

    // Run one compare on instance u.
    //   immediate: drive start now (we are already in a done cycle), not at the next negedge
    //   noisy:     scramble a/b and toggle start while the instance is busy
    //   stay:      return inside the done cycle so the caller can chain a start
    task automatic run_cmp(input int u, input logic [15:0] a, input logic [15:0] b,
                           input bit immediate, input bit noisy, input bit stay);
        exp_t        x;
        exp_t        got_x;
        logic [15:0] am;
        logic [15:0] bm;
        int          cnt;
        bit          got;
        am   = a & unit_mask(u);
        bm   = b & unit_mask(u);
        x.e  = (am == bm);
        x.g  = (am > bm);
        x.l  = (am < bm);
        x.p  = first_diff(am, bm, unit_width(u));
        sb.push_back(x);

        if (!immediate) @(negedge clk);
        a_v[u]     = a;
        b_v[u]     = b;
        start_v[u] = 1'b1;
        @(posedge clk);
        #1;
        start_v[u] = 1'b0;
        check("accept_busy", 32'(busy_v[u]), 32'd1);
        check("accept_done", 32'(done_v[u]), 32'd0);
        check("accept_egl", egl(u), 32'd0);

        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 40) begin
            if (noisy) begin
                a_v[u]     = 16'($urandom);
                b_v[u]     = 16'($urandom);
                start_v[u] = ~start_v[u];
            end
            @(posedge clk);
            #1;
            cnt++;
            if (done_v[u]) got = 1'b1;
        end
        start_v[u] = 1'b0;

        check("done_seen", 32'(got), 32'd1);
        got_x = sb.pop_front();
        check("latency", 32'(cnt), 32'(got_x.p));
        check("result_egl", egl(u), {29'd0, got_x.e, got_x.g, got_x.l});
        check("done_busy", 32'(busy_v[u]), 32'd0);

        if (!stay) begin
            @(posedge clk);
            #1;
            check("done_pulse", 32'(done_v[u]), 32'd0);
            check("egl_hold", egl(u), {29'd0, got_x.e, got_x.g, got_x.l});
        end
    endtask

    initial begin
        int seen;
        int mode;
        int nib;
        logic [15:0] ra;
        logic [15:0] rb;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            a_v[u]     = 16'h0;
            b_v[u]     = 16'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("reset_busy", 32'(busy_v[u]), 32'd0);
            check("reset_done", 32'(done_v[u]), 32'd0);
            check("reset_egl", egl(u), 32'd0);
        end
        rst = 1'b0;

        // Reset mid-compare: equal operands, rst one edge after accept
        @(negedge clk);
        a_v[0]     = 16'h1234;
        b_v[0]     = 16'h1234;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("midrst_busy_before", 32'(busy_v[0]), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        check("midrst_done", 32'(done_v[0]), 32'd0);
        check("midrst_egl", egl(0), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        // Directed cases on WIDTH=16
        run_cmp(0, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);  // MSB differs, p=1
        run_cmp(0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);  // equal, p=4
        run_cmp(0, 16'h1230, 16'h1231, 1'b0, 1'b0, 1'b0);  // LSB differs, p=4
        run_cmp(0, 16'h12F0, 16'h1300, 1'b0, 1'b0, 1'b0);  // nibble 2 differs, p=2

        // Handshake: noise while busy, then a start in the done cycle
        run_cmp(0, 16'h1234, 16'h1200, 1'b0, 1'b1, 1'b1);  // p=3, g
        run_cmp(0, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0);  // chained, p=4, g
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_v[0]) seen++;
        end
        check("handshake_no_extra_done", 32'(seen), 32'd0);

        // Randomized sweep over all three widths
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 12; k++) begin
                ra   = 16'($urandom);
                mode = $urandom_range(0, 2);
                nib  = $urandom_range(0, unit_width(u) / 4 - 1);
                if (mode == 0) rb = ra;
                else if (mode == 1) rb = ra ^ (16'(4'($urandom_range(1, 15))) << (4 * nib));
                else rb = 16'($urandom);
                run_cmp(u, ra, rb, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_comparator
